// File: rtl/dis_pal_pkg.sv
// -----------------------------------------------------------------------------
// dis_pal_pkg
// Shared definitions for the PAL Avalon-ST video test-pattern generator:
// packet type nibbles, control packet length, FSM state encoding, pattern
// mode encoding and the helper that selects a control packet body nibble.
// -----------------------------------------------------------------------------
package dis_pal_pkg;

    // Packet type nibble carried in the low four bits of a header beat.
    localparam logic [3:0] PKT_CTRL  = 4'hF;
    localparam logic [3:0] PKT_VIDEO = 4'h0;

    // Control packet body: 4 width nibbles, 4 height nibbles, 1 interlace.
    localparam int CTRL_BODY_LEN = 9;

    // Width of the x/y/bar counters; matches the 16-bit control packet fields.
    localparam int CNT_W = 16;

    // Colour-bar index saturates at the eighth bar.
    localparam logic [2:0] BAR_IDX_MAX = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CTRL_HDR  = 3'd1,
        ST_CTRL_BODY = 3'd2,
        ST_VID_HDR   = 3'd3,
        ST_VID_BODY  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_RAMP    = 2'd1,
        MODE_BARS    = 2'd2,
        MODE_CHECKER = 2'd3
    } mode_t;

    // Body beat idx of the control packet: width and height MSB nibble first,
    // then the interlace nibble.
    function automatic logic [3:0] ctrl_nibble(
        input logic [3:0]  idx,
        input logic [15:0] width,
        input logic [15:0] height,
        input logic [3:0]  interlace
    );
        logic [3:0] nib;
        case (idx)
            4'd0:    nib = width[15:12];
            4'd1:    nib = width[11:8];
            4'd2:    nib = width[7:4];
            4'd3:    nib = width[3:0];
            4'd4:    nib = height[15:12];
            4'd5:    nib = height[11:8];
            4'd6:    nib = height[7:4];
            4'd7:    nib = height[3:0];
            default: nib = interlace;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/dis_pal_pattern_pixel.sv
// -----------------------------------------------------------------------------
// dis_pal_pattern_pixel
// Purely combinational pixel generator for one colour plane.
// Ports:
//   i_mode        pattern selector (solid / ramp / bars / checker)
//   i_x, i_y      pixel coordinates within the field
//   i_bar_idx     current colour-bar index (0..7), kept by the sequencer
//   i_solid_level value used in solid mode
//   o_pixel       pixel value, DATA_WIDTH bits
// -----------------------------------------------------------------------------
module dis_pal_pattern_pixel
    import dis_pal_pkg::*;
#(
    parameter int DATA_WIDTH = 10
) (
    input  mode_t                  i_mode,
    input  logic [CNT_W-1:0]       i_x,
    input  logic [CNT_W-1:0]       i_y,
    input  logic [2:0]             i_bar_idx,
    input  logic [DATA_WIDTH-1:0]  i_solid_level,
    output logic [DATA_WIDTH-1:0]  o_pixel
);

    // Only the low x bits and bit 4 of x/y feed the patterns.
    logic w_unused_bits;
    assign w_unused_bits = ^{i_x, i_y};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case statement leaves it unassigned (no latch).
        o_pixel = '0;
        case (i_mode)
            MODE_SOLID:   o_pixel = i_solid_level;
            MODE_RAMP:    o_pixel = DATA_WIDTH'(i_x);
            // Bar index occupies the three MSBs; the rest of the word is zero.
            MODE_BARS:    o_pixel = {i_bar_idx, {(DATA_WIDTH-3){1'b0}}};
            MODE_CHECKER: o_pixel = (i_x[4] ^ i_y[4]) ? '1 : '0;
            default:      o_pixel = '0;
        endcase
    end

endmodule

// File: rtl/dis_pal_vst_pattern.sv
// -----------------------------------------------------------------------------
// dis_pal_vst_pattern
// Avalon-ST video test-pattern source. Each frame is a control packet
// (header + 9 nibble beats carrying width/height/interlace) followed by a
// video packet (header + IM_WIDTH*IM_HEIGHT pixels in raster order).
// Ports:
//   vst_clk, vst_rst          clock, synchronous active-high reset
//   enable                    frame generation allowed
//   mode, solid_level         pattern select and solid value (latched per frame)
//   vst_data/valid/ready      Avalon-ST stream, ready latency 0
//   vst_startofpacket/endofpacket  packet delimiters
//   frame_done                one-cycle pulse after the last pixel transfers
// All stream outputs are registered; a new beat is loaded only when the
// current one transfers, so outputs hold stable under backpressure.
// -----------------------------------------------------------------------------
module dis_pal_vst_pattern
    import dis_pal_pkg::*;
#(
    parameter int         DATA_WIDTH       = 10,
    parameter int         IM_WIDTH         = 720,
    parameter int         IM_HEIGHT        = 288,
    parameter logic [3:0] INTERLACE_NIBBLE = 4'b0000,
    parameter int         BAR_W            = 90
) (
    input  logic                  vst_clk,
    input  logic                  vst_rst,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] solid_level,
    output logic [DATA_WIDTH-1:0] vst_data,
    output logic                  vst_valid,
    input  logic                  vst_ready,
    output logic                  vst_startofpacket,
    output logic                  vst_endofpacket,
    output logic                  frame_done
);

    localparam logic [15:0]      W16       = 16'(IM_WIDTH);
    localparam logic [15:0]      H16       = 16'(IM_HEIGHT);
    localparam logic [CNT_W-1:0] X_LAST    = CNT_W'(IM_WIDTH - 1);
    localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(IM_HEIGHT - 1);
    localparam logic [CNT_W-1:0] BAR_LAST  = CNT_W'(BAR_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       CTRL_LAST = 4'(CTRL_BODY_LEN - 1);

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_valid;
    logic                    r_sop;
    logic                    r_eop;
    logic                    r_frame_done;
    logic [3:0]              r_ctrl_idx;
    mode_t                   r_mode;
    logic [DATA_WIDTH-1:0]   r_solid;
    // Coordinates and bar state of the pixel currently on the output.
    logic [CNT_W-1:0]        r_x;
    logic [CNT_W-1:0]        r_y;
    logic [CNT_W-1:0]        r_bar_cnt;
    logic [2:0]              r_bar_idx;

    logic                    w_xfer;
    logic                    w_last_pix;
    logic                    w_next_last;
    logic [CNT_W-1:0]        w_nx;
    logic [CNT_W-1:0]        w_ny;
    logic [CNT_W-1:0]        w_nbar_cnt;
    logic [2:0]              w_nbar_idx;
    logic [DATA_WIDTH-1:0]   w_pix;

    assign w_xfer     = r_valid & vst_ready;
    assign w_last_pix = (r_state == ST_VID_BODY) && (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_next_last = (w_nx == X_LAST) && (w_ny == Y_LAST);

    // Coordinates of the pixel that follows the one on the output. Outside
    // VID_BODY (i.e. leaving VID_HDR) the next pixel is the frame origin.
    always_comb begin
        w_nx       = '0;
        w_ny       = '0;
        w_nbar_cnt = '0;
        w_nbar_idx = '0;
        if (r_state == ST_VID_BODY) begin
            if (r_x == X_LAST) begin
                // Line wrap: bar tracking restarts with the new line.
                w_ny = (r_y == Y_LAST) ? '0 : r_y + CNT_ONE;
            end else begin
                w_nx = r_x + CNT_ONE;
                w_ny = r_y;
                if (r_bar_cnt == BAR_LAST) begin
                    w_nbar_idx = (r_bar_idx == BAR_IDX_MAX) ? BAR_IDX_MAX : r_bar_idx + 3'd1;
                end else begin
                    w_nbar_cnt = r_bar_cnt + CNT_ONE;
                    w_nbar_idx = r_bar_idx;
                end
            end
        end
    end

    dis_pal_pattern_pixel #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pixel (
        .i_mode        (r_mode),
        .i_x           (w_nx),
        .i_y           (w_ny),
        .i_bar_idx     (w_nbar_idx),
        .i_solid_level (r_solid),
        .o_pixel       (w_pix)
    );

    // Each state owns the beat currently on the output; on its transfer the
    // next beat is loaded in the same edge, so there are no bubbles.
    always_ff @(posedge vst_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (vst_rst) begin
            r_state      <= ST_IDLE;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_frame_done <= 1'b0;
            r_ctrl_idx   <= '0;
            r_mode       <= MODE_SOLID;
            r_solid      <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_bar_cnt    <= '0;
            r_bar_idx    <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= ST_CTRL_HDR;
                        r_valid <= 1'b1;
                        r_data  <= DATA_WIDTH'(PKT_CTRL);
                        r_sop   <= 1'b1;
                        r_eop   <= 1'b0;
                    end
                end

                ST_CTRL_HDR: begin
                    if (w_xfer) begin
                        // Pattern settings are frozen for the whole frame here.
                        r_mode     <= mode_t'(mode);
                        r_solid    <= solid_level;
                        r_state    <= ST_CTRL_BODY;
                        r_ctrl_idx <= '0;
                        r_data     <= DATA_WIDTH'(ctrl_nibble(4'd0, W16, H16, INTERLACE_NIBBLE));
                        r_sop      <= 1'b0;
                        r_eop      <= 1'b0;
                    end
                end

                ST_CTRL_BODY: begin
                    if (w_xfer) begin
                        if (r_ctrl_idx == CTRL_LAST) begin
                            r_state <= ST_VID_HDR;
                            r_data  <= DATA_WIDTH'(PKT_VIDEO);
                            r_sop   <= 1'b1;
                            r_eop   <= 1'b0;
                        end else begin
                            r_ctrl_idx <= r_ctrl_idx + 4'd1;
                            r_data     <= DATA_WIDTH'(ctrl_nibble(r_ctrl_idx + 4'd1, W16, H16,
                                                                  INTERLACE_NIBBLE));
                            r_eop      <= (r_ctrl_idx + 4'd1 == CTRL_LAST);
                        end
                    end
                end

                ST_VID_HDR: begin
                    if (w_xfer) begin
                        r_state   <= ST_VID_BODY;
                        r_x       <= w_nx;
                        r_y       <= w_ny;
                        r_bar_cnt <= w_nbar_cnt;
                        r_bar_idx <= w_nbar_idx;
                        r_data    <= w_pix;
                        r_sop     <= 1'b0;
                        r_eop     <= w_next_last;
                    end
                end

                ST_VID_BODY: begin
                    if (w_xfer) begin
                        if (w_last_pix) begin
                            r_frame_done <= 1'b1;
                            r_x          <= '0;
                            r_y          <= '0;
                            r_bar_cnt    <= '0;
                            r_bar_idx    <= '0;
                            if (enable) begin
                                r_state <= ST_CTRL_HDR;
                                r_data  <= DATA_WIDTH'(PKT_CTRL);
                                r_sop   <= 1'b1;
                                r_eop   <= 1'b0;
                            end else begin
                                r_state <= ST_IDLE;
                                r_valid <= 1'b0;
                                r_data  <= '0;
                                r_sop   <= 1'b0;
                                r_eop   <= 1'b0;
                            end
                        end else begin
                            r_x       <= w_nx;
                            r_y       <= w_ny;
                            r_bar_cnt <= w_nbar_cnt;
                            r_bar_idx <= w_nbar_idx;
                            r_data    <= w_pix;
                            r_eop     <= w_next_last;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign vst_data          = r_data;
    assign vst_valid         = r_valid;
    assign vst_startofpacket = r_sop;
    assign vst_endofpacket   = r_eop;
    assign frame_done        = r_frame_done;

endmodule

// File: tb/tb_dis_pal_vst_pattern.sv
// -----------------------------------------------------------------------------
// tb_dis_pal_vst_pattern
// Directed bench for dis_pal_vst_pattern with a reduced 40x18 field,
// BAR_W=4 (so bar saturation is reachable) and interlace nibble 4'b0101.
// Control body for these parameters: width 0x0028, height 0x0012, 0x5.
// -----------------------------------------------------------------------------
module tb_dis_pal_vst_pattern;

    localparam int DW   = 10;
    localparam int W    = 40;
    localparam int H    = 18;
    localparam int BW   = 4;
    localparam int NPIX = W * H;

    logic          vst_clk = 1'b0;
    logic          vst_rst;
    logic          enable;
    logic [1:0]    mode;
    logic [DW-1:0] solid_level;
    logic [DW-1:0] vst_data;
    logic          vst_valid;
    logic          vst_ready;
    logic          vst_startofpacket;
    logic          vst_endofpacket;
    logic          frame_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0]    exp_ctrl [9];
    logic [DW-1:0] frame_px [NPIX];

    bit            stall_pending = 0;
    logic [DW-1:0] st_d;
    logic          st_s;
    logic          st_e;

    always #5 vst_clk = ~vst_clk;

    dis_pal_vst_pattern #(
        .DATA_WIDTH       (DW),
        .IM_WIDTH         (W),
        .IM_HEIGHT        (H),
        .INTERLACE_NIBBLE (4'b0101),
        .BAR_W            (BW)
    ) dut (
        .vst_clk           (vst_clk),
        .vst_rst           (vst_rst),
        .enable            (enable),
        .mode              (mode),
        .solid_level       (solid_level),
        .vst_data          (vst_data),
        .vst_valid         (vst_valid),
        .vst_ready         (vst_ready),
        .vst_startofpacket (vst_startofpacket),
        .vst_endofpacket   (vst_endofpacket),
        .frame_done        (frame_done)
    );

    // Reference pixel value, written from the pattern definitions directly.
    function automatic logic [DW-1:0] model_pix(input int m, input int x, input int y,
                                                input logic [DW-1:0] s);
        int b;
        case (m)
            0: return s;
            1: return DW'(x % (1 << DW));
            2: begin
                b = x / BW;
                if (b > 7) b = 7;
                return DW'(b * 128);
            end
            default: return (((x / 16) % 2) != ((y / 16) % 2)) ? '1 : '0;
        endcase
    endfunction

    // Waits for one transfer; ready is driven at the falling edge and the beat
    // is captured there, transferring on the following rising edge. While a
    // beat stalls, its contents must not change.
    task automatic get_beat(input bit rand_rdy, output logic [DW-1:0] d, output logic s,
                            output logic e, output int waited);
        bit got;
        got    = 0;
        waited = 0;
        while (!got) begin
            @(negedge vst_clk);
            waited++;
            if (stall_pending) begin
                n_cmp++;
                if (vst_valid !== 1'b1 || vst_data !== st_d || vst_startofpacket !== st_s ||
                    vst_endofpacket !== st_e) begin
                    n_err++;
                    $display("FAIL stall_hold: valid=%b data=%h sop=%b eop=%b, required valid=1 data=%h sop=%b eop=%b",
                             vst_valid, vst_data, vst_startofpacket, vst_endofpacket, st_d, st_s, st_e);
                end
            end
            vst_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (vst_valid === 1'b1 && vst_ready) begin
                d = vst_data; s = vst_startofpacket; e = vst_endofpacket;
                got = 1;
                stall_pending = 0;
            end else if (vst_valid === 1'b1) begin
                stall_pending = 1;
                st_d = vst_data; st_s = vst_startofpacket; st_e = vst_endofpacket;
            end else begin
                stall_pending = 0;
            end
            if (!got && waited >= 400) begin
                n_cmp++;
                n_err++;
                $display("FAIL beat_timeout: no transfer after %0d cycles, required a beat", waited);
                d = 'x; s = 1'bx; e = 1'bx;
                got = 1;
            end
        end
    endtask

    // Receives one whole frame and checks every beat. Optionally changes the
    // mode/solid inputs or drops enable at a given pixel index.
    task automatic check_frame(input string tag, input int exp_mode, input logic [DW-1:0] exp_solid,
                               input bit rand_rdy, input int change_at, input logic [1:0] new_mode,
                               input logic [DW-1:0] new_solid, input int drop_at);
        logic [DW-1:0] d;
        logic          s;
        logic          e;
        logic [DW-1:0] exp_px;
        int            wt;
        int            bubbles;
        bubbles = 0;

        get_beat(rand_rdy, d, s, e, wt);
        n_cmp++;
        if (d !== DW'(4'hF) || s !== 1'b1 || e !== 1'b0) begin
            n_err++;
            $display("FAIL %s ctrl_hdr: data=%h sop=%b eop=%b, required data=00f sop=1 eop=0", tag, d, s, e);
        end

        for (int i = 0; i < 9; i++) begin
            get_beat(rand_rdy, d, s, e, wt);
            if (wt != 1) bubbles++;
            n_cmp++;
            if (d !== DW'(exp_ctrl[i]) || s !== 1'b0 || e !== (i == 8)) begin
                n_err++;
                $display("FAIL %s ctrl_body[%0d]: data=%h sop=%b eop=%b, required data=%h sop=0 eop=%b",
                         tag, i, d, s, e, DW'(exp_ctrl[i]), (i == 8));
            end
        end

        get_beat(rand_rdy, d, s, e, wt);
        if (wt != 1) bubbles++;
        n_cmp++;
        if (d !== '0 || s !== 1'b1 || e !== 1'b0) begin
            n_err++;
            $display("FAIL %s vid_hdr: data=%h sop=%b eop=%b, required data=000 sop=1 eop=0", tag, d, s, e);
        end

        for (int p = 0; p < NPIX; p++) begin
            if (p == change_at) begin
                mode        = new_mode;
                solid_level = new_solid;
            end
            if (p == drop_at) enable = 1'b0;
            get_beat(rand_rdy, d, s, e, wt);
            if (wt != 1) bubbles++;
            frame_px[p] = d;
            exp_px = model_pix(exp_mode, p % W, p / W, exp_solid);
            n_cmp++;
            if (d !== exp_px || s !== 1'b0 || e !== (p == NPIX - 1)) begin
                n_err++;
                $display("FAIL %s pixel(%0d,%0d): data=%h sop=%b eop=%b, required data=%h sop=0 eop=%b",
                         tag, p % W, p / W, d, s, e, exp_px, (p == NPIX - 1));
            end
        end

        if (!rand_rdy) begin
            n_cmp++;
            if (bubbles != 0) begin
                n_err++;
                $display("FAIL %s no_bubbles: %0d idle cycles, required 0", tag, bubbles);
            end
        end

        // Last pixel transfers at the coming rising edge; frame_done follows.
        @(negedge vst_clk);
        vst_ready     = 1'b0;
        stall_pending = 0;
        n_cmp++;
        if (frame_done !== 1'b1) begin
            n_err++;
            $display("FAIL %s frame_done_pulse: got %b, required 1", tag, frame_done);
        end
        if (!enable) begin
            n_cmp++;
            if (vst_valid !== 1'b0) begin
                n_err++;
                $display("FAIL %s idle_after_frame: valid=%b, required 0", tag, vst_valid);
            end
        end
        @(negedge vst_clk);
        n_cmp++;
        if (frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL %s frame_done_width: got %b, required 0", tag, frame_done);
        end
    endtask

    task automatic test_reset();
        vst_rst     = 1'b1;
        enable      = 1'b0;
        mode        = 2'd0;
        solid_level = '0;
        vst_ready   = 1'b0;
        repeat (3) @(negedge vst_clk);
        n_cmp++;
        if (vst_valid !== 1'b0 || vst_data !== '0 || vst_startofpacket !== 1'b0 ||
            vst_endofpacket !== 1'b0 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%b data=%h sop=%b eop=%b done=%b, required all 0",
                     vst_valid, vst_data, vst_startofpacket, vst_endofpacket, frame_done);
        end
        vst_rst = 1'b0;
        repeat (3) @(negedge vst_clk);
        n_cmp++;
        if (vst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_enable: valid=%b, required 0", vst_valid);
        end
    endtask

    task automatic test_ramp();
        mode   = 2'd1;
        enable = 1'b1;
        check_frame("ramp", 1, '0, 1'b0, -1, 2'd1, '0, -1);
        n_cmp++;
        if (frame_px[7] !== 10'd7 || frame_px[39] !== 10'd39 || frame_px[40] !== 10'd0) begin
            n_err++;
            $display("FAIL ramp_spot: px7=%0d px39=%0d px40=%0d, required 7 39 0",
                     frame_px[7], frame_px[39], frame_px[40]);
        end
    endtask

    task automatic test_mode_switch();
        // Mode input changes mid-frame; this frame stays ramp, next is checker.
        check_frame("switch_cur", 1, '0, 1'b0, 100, 2'd3, '0, -1);
        check_frame("switch_next", 3, '0, 1'b0, -1, 2'd3, '0, -1);
        n_cmp++;
        if (frame_px[16] !== 10'h3FF || frame_px[15] !== 10'h000 ||
            frame_px[16*W] !== 10'h3FF || frame_px[16*W + 16] !== 10'h000) begin
            n_err++;
            $display("FAIL checker_spot: (16,0)=%h (15,0)=%h (0,16)=%h (16,16)=%h, required 3ff 000 3ff 000",
                     frame_px[16], frame_px[15], frame_px[16*W], frame_px[16*W + 16]);
        end
    endtask

    task automatic test_solid_backpressure();
        mode        = 2'd0;
        solid_level = 10'h2A5;
        check_frame("solid_stall", 0, 10'h2A5, 1'b1, 50, 2'd0, 10'h0F0, -1);
    endtask

    task automatic test_bars_enable_drop();
        int idle_bad;
        mode = 2'd2;
        check_frame("bars", 2, '0, 1'b0, -1, 2'd2, '0, 300);
        n_cmp++;
        if (frame_px[3] !== 10'd0 || frame_px[4] !== 10'd128 || frame_px[8] !== 10'd256 ||
            frame_px[28] !== 10'd896 || frame_px[39] !== 10'd896 || frame_px[40] !== 10'd0) begin
            n_err++;
            $display("FAIL bars_spot: x3=%0d x4=%0d x8=%0d x28=%0d x39=%0d next_line=%0d, required 0 128 256 896 896 0",
                     frame_px[3], frame_px[4], frame_px[8], frame_px[28], frame_px[39], frame_px[40]);
        end
        idle_bad = 0;
        vst_ready = 1'b1;
        repeat (20) begin
            @(negedge vst_clk);
            if (vst_valid !== 1'b0 || vst_startofpacket !== 1'b0) idle_bad++;
        end
        n_cmp++;
        if (idle_bad != 0) begin
            n_err++;
            $display("FAIL stays_idle: %0d active cycles with enable low, required 0", idle_bad);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [DW-1:0] d;
        logic          s;
        logic          e;
        int            wt;
        mode   = 2'd1;
        enable = 1'b1;
        get_beat(1'b0, d, s, e, wt);
        n_cmp++;
        if (d !== DW'(4'hF) || s !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid hdr: data=%h sop=%b, required data=00f sop=1", d, s);
        end
        for (int i = 0; i < 4; i++) get_beat(1'b0, d, s, e, wt);
        // Body beat 5 is now on the output; reset while it stalls.
        @(negedge vst_clk);
        vst_ready = 1'b0;
        n_cmp++;
        if (vst_valid !== 1'b1 || vst_data !== DW'(exp_ctrl[4])) begin
            n_err++;
            $display("FAIL rst_mid beat5: valid=%b data=%h, required valid=1 data=%h",
                     vst_valid, vst_data, DW'(exp_ctrl[4]));
        end
        vst_rst = 1'b1;
        @(negedge vst_clk);
        n_cmp++;
        if (vst_valid !== 1'b0 || vst_endofpacket !== 1'b0 || vst_startofpacket !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid abort: valid=%b sop=%b eop=%b, required 0 0 0",
                     vst_valid, vst_startofpacket, vst_endofpacket);
        end
        vst_rst = 1'b0;
        check_frame("after_rst", 1, '0, 1'b0, -1, 2'd1, '0, -1);
    endtask

    initial begin
        exp_ctrl = '{4'h0, 4'h0, 4'h2, 4'h8, 4'h0, 4'h0, 4'h1, 4'h2, 4'h5};
        test_reset();
        test_ramp();
        test_mode_switch();
        test_solid_backpressure();
        test_bars_enable_drop();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
